// File: rtl/sio_target_bus.sv
// sio_target_bus: queues 80-bit link command words in a small FIFO and
// replays them as writes/reads on a valid/ready local register bus.
// The most recent read result (or DEADBEEF on timeout) is held on rdata.
module sio_target_bus #(
    parameter int AW      = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          c,
    input  logic          r,
    input  logic [79:0]   wdata,
    input  logic          wvalid,
    output logic [31:0]   rdata,
    output logic [AW-1:0] bus_addr,
    output logic [31:0]   bus_wdata,
    output logic          bus_we,
    output logic          bus_valid,
    input  logic          bus_ready,
    input  logic [31:0]   bus_rdata,
    input  logic          bus_rvalid,
    output logic [15:0]   status
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 2 + AW + 32;
    localparam logic [PW:0] FULL   = (PW+1)'(DEPTH);
    localparam logic [7:0]  T_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RWAIT} state_t;

    state_t          r_state, w_next;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [PW:0]     r_count;
    logic [1:0]      r_op;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [7:0]      r_wcnt;
    logic [7:0]      r_ovf;
    logic [7:0]      r_tmo;

    logic [1:0]      w_op_in;
    logic            w_push_req, w_push, w_pop, w_expire;
    logic [EW-1:0]   w_head;
    logic            w_unused;

    assign w_op_in    = wdata[79:78];
    assign w_push_req = wvalid && (w_op_in != 2'd0);
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    // A full FIFO still takes a command when the head leaves in the same cycle.
    assign w_push     = w_push_req && ((r_count < FULL) || w_pop);
    assign w_head     = r_mem[r_rptr];
    assign w_expire   = (r_wcnt == T_LAST);
    // Reserved bits and address bits above AW are intentionally ignored.
    assign w_unused   = ^{wdata[77:64], wdata[63:32]};

    assign rdata     = r_rdata;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign status    = {r_ovf, r_tmo};

    // Command storage (no reset needed: occupancy is tracked by pointers).
    always_ff @(posedge c) begin
        if (w_push) r_mem[r_wptr] <= {w_op_in, wdata[32+AW-1:32], wdata[31:0]};
    end

    // FIFO pointers and occupancy; overflow counter saturates at 255.
    always_ff @(posedge c) begin
        if (r) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push && r_ovf != 8'hFF) r_ovf <= r_ovf + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge c) begin
        if (r) r_state <= S_IDLE;
        else   r_state <= w_next;
    end

    // Next-state and bus strobes; request fields come from registers so they
    // stay stable while the bus stalls.
    always_comb begin
        w_next    = r_state;
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        case (r_state)
            S_IDLE:  if (w_pop) w_next = (w_head[EW-1 -: 2] == 2'd2) ? S_RD : S_WR;
            S_WR: begin
                bus_valid = 1'b1;
                bus_we    = 1'b1;
                if (bus_ready) w_next = (r_op == 2'd3) ? S_RD : S_IDLE;
            end
            S_RD: begin
                bus_valid = 1'b1;
                if (bus_ready) w_next = S_RWAIT;
            end
            S_RWAIT: if (bus_rvalid || w_expire) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch on pop, read wait counter, read result and timeout count.
    always_ff @(posedge c) begin
        if (r) begin
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wcnt  <= '0;
            r_tmo   <= '0;
        end else begin
            if (w_pop) {r_op, r_addr, r_wdata} <= w_head;
            if (r_state == S_RD && bus_ready) r_wcnt <= '0;
            if (r_state == S_RWAIT) begin
                // A response arriving on the expiry cycle still counts as success.
                if (bus_rvalid) begin
                    r_rdata <= bus_rdata;
                end else if (w_expire) begin
                    r_rdata <= 32'hDEADBEEF;
                    if (r_tmo != 8'hFF) r_tmo <= r_tmo + 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sio_target_bus.sv
// Directed bench for sio_target_bus: expected bus transactions are queued
// by the stimulus and checked by an independent monitor on every handshake.
module tb_sio_target_bus;

    logic        c = 1'b0;
    logic        r = 1'b1;
    logic [79:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic [31:0] rdata;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we, bus_valid;
    logic        bus_ready = 1'b1;
    logic [31:0] bus_rdata = '0;
    logic        bus_rvalid = 1'b0;
    logic [15:0] status;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];

    sio_target_bus #(.AW(16), .DEPTH(4), .TIMEOUT(255)) dut (
        .c(c), .r(r), .wdata(wdata), .wvalid(wvalid), .rdata(rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .bus_rvalid(bus_rvalid), .status(status)
    );

    always #5 c = ~c;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: pops the scoreboard on each accepted request and checks
    // that a stalled request holds its fields.
    logic        p_stall = 1'b0;
    logic        p_we;
    logic [15:0] p_addr;
    logic [31:0] p_wd;
    always @(negedge c) begin
        txn_t e;
        if (!r) begin
            if (p_stall && bus_valid) begin
                total++;
                if (bus_we !== p_we || bus_addr !== p_addr || bus_wdata !== p_wd) begin
                    bad++;
                    $display("FAIL hold: got we=%0b addr=%h wd=%h, need we=%0b addr=%h wd=%h",
                             bus_we, bus_addr, bus_wdata, p_we, p_addr, p_wd);
                end
            end
            if (bus_valid && bus_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bus_txn: unexpected we=%0b addr=%h wd=%h, need none",
                             bus_we, bus_addr, bus_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_we !== e.we || bus_addr !== e.addr || (e.we && bus_wdata !== e.data)) begin
                        bad++;
                        $display("FAIL bus_txn: got we=%0b addr=%h wd=%h, need we=%0b addr=%h wd=%h",
                                 bus_we, bus_addr, bus_wdata, e.we, e.addr, e.data);
                    end
                end
            end
        end
        p_stall = !r && bus_valid && !bus_ready;
        p_we    = bus_we;
        p_addr  = bus_addr;
        p_wd    = bus_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data);
        @(posedge c); #1;
        wvalid = 1'b1;
        wdata  = {op, 14'd0, 16'd0, addr, data};
        @(posedge c); #1;
        wvalid = 1'b0;
    endtask

    task automatic expect_txn(input logic we, input logic [15:0] addr, input logic [31:0] data);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data;
        exp_q.push_back(t);
    endtask

    // Returns at the negedge of the cycle in which a read is accepted.
    task automatic wait_rd_accept(input string name);
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge c);
            if (bus_valid && !bus_we && bus_ready) found = 1;
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL %s: read accept not seen within 100 cycles", name);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge c);
        #1;
        chk("rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_we", {31'd0, bus_we}, 32'd0);
        chk("rst_addr", {16'd0, bus_addr}, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_status", {16'd0, status}, 32'd0);
        r = 1'b0;

        // Single write, ready tied high: valid exactly in cycle 2
        expect_txn(1'b1, 16'h0012, 32'hCAFEF00D);
        send(2'd1, 16'h0012, 32'hCAFEF00D);
        @(posedge c); #1;
        chk("wr_c2_valid", {30'd0, bus_valid, bus_we}, 32'd3);
        chk("wr_c2_wdata", bus_wdata, 32'hCAFEF00D);
        @(posedge c); #1;
        chk("wr_c3_valid", {31'd0, bus_valid}, 32'd0);
        chk("wr_rdata", rdata, 32'd0);

        // Read with ready delayed three cycles
        bus_ready = 1'b0;
        expect_txn(1'b0, 16'h0040, 32'd0);
        send(2'd2, 16'h0040, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge c); #1;
            chk("rd_stall_valid", {30'd0, bus_valid, bus_we}, 32'd2);
            chk("rd_stall_addr", {16'd0, bus_addr}, 32'h40);
        end
        @(posedge c); #1;
        chk("rd_c5_valid", {31'd0, bus_valid}, 32'd1);
        bus_ready = 1'b1;
        @(posedge c); #1;
        bus_ready = 1'b0;
        chk("rd_rwait_valid", {31'd0, bus_valid}, 32'd0);
        repeat (4) @(posedge c);
        #1;
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        @(posedge c); #1;
        bus_rvalid = 1'b0;
        chk("rd_rdata", rdata, 32'h12345678);
        bus_ready = 1'b1;

        // Write-then-read on the same address
        expect_txn(1'b1, 16'h0005, 32'h000000A5);
        expect_txn(1'b0, 16'h0005, 32'd0);
        send(2'd3, 16'h0005, 32'h000000A5);
        wait_rd_accept("wtr_accept");
        @(posedge c); #1;
        bus_rvalid = 1'b1; bus_rdata = 32'h000000A5;
        @(posedge c); #1;
        bus_rvalid = 1'b0;
        chk("wtr_rdata", rdata, 32'h000000A5);

        // Timeout: no response for 255 cycles
        expect_txn(1'b0, 16'h0077, 32'd0);
        send(2'd2, 16'h0077, 32'd0);
        wait_rd_accept("to1_accept");
        repeat (255) @(posedge c);
        #1;
        chk("to1_not_yet", rdata, 32'h000000A5);
        @(posedge c); #1;
        chk("to1_rdata", rdata, 32'hDEADBEEF);
        chk("to1_count", {24'd0, status[7:0]}, 32'd1);

        // Response exactly on the expiry cycle wins
        expect_txn(1'b0, 16'h0078, 32'd0);
        send(2'd2, 16'h0078, 32'd0);
        wait_rd_accept("to2_accept");
        repeat (255) @(posedge c);
        #1;
        bus_rvalid = 1'b1; bus_rdata = 32'h0BADF00D;
        @(posedge c); #1;
        bus_rvalid = 1'b0;
        chk("to2_rdata", rdata, 32'h0BADF00D);
        chk("to2_count", {24'd0, status[7:0]}, 32'd1);

        // Overflow: six back-to-back writes while the bus stalls.
        // #1 is popped the cycle #2 arrives, #2..#5 fill the FIFO, #6 drops.
        bus_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge c); #1;
            wvalid = 1'b1;
            wdata  = {2'd1, 14'd0, 16'd0, 16'(16'h0100 + k), 32'(32'h1000 + k)};
            if (k < 5) expect_txn(1'b1, 16'(16'h0100 + k), 32'(32'h1000 + k));
        end
        @(posedge c); #1;
        wvalid = 1'b0;
        chk("ovf_count", {24'd0, status[15:8]}, 32'd1);
        bus_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge c);
        repeat (4) @(posedge c);
        #1;
        chk("ovf_drained", exp_q.size(), 32'd0);
        chk("ovf_idle", {31'd0, bus_valid}, 32'd0);

        // Reset while waiting for read data; late response is ignored
        expect_txn(1'b0, 16'h0033, 32'd0);
        send(2'd2, 16'h0033, 32'd0);
        wait_rd_accept("rst_rd_accept");
        @(posedge c); #1;
        r = 1'b1;
        @(posedge c); #1;
        r = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF0000;
        @(posedge c); #1;
        bus_rvalid = 1'b0;
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("mid_rst_status", {16'd0, status}, 32'd0);
        begin
            bit seen = 0;
            send(2'd0, 16'h0099, 32'h5555AAAA);
            for (int i = 0; i < 8; i++) begin
                @(posedge c); #1;
                if (bus_valid) seen = 1;
            end
            chk("nop_no_bus", {31'd0, seen}, 32'd0);
        end
        chk("final_queue", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
